// File: rtl/apb_requester_bridge_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : apb_requester_bridge_if
// Brief    : APB bus bundle shared by the requester bridge and its completer.
// Revision : 1.0 - initial release
// ============================================================================
interface apb_requester_bridge_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int USER_WIDTH = 1
);
  logic                      pclk;
  logic                      preset_n;
  logic [ADDR_WIDTH-1:0]     paddr;
  logic                      psel;
  logic                      penable;
  logic                      pwrite;
  logic [DATA_WIDTH-1:0]     pwdata;
  logic [DATA_WIDTH/8-1:0]   pstrb;
  logic [2:0]                pprot;
  logic                      pwakeup;
  logic [USER_WIDTH-1:0]     pauser;
  logic [USER_WIDTH-1:0]     pwuser;
  logic [DATA_WIDTH-1:0]     prdata;
  logic                      pready;
  logic                      pslverr;
  logic [USER_WIDTH-1:0]     pruser;
  logic [USER_WIDTH-1:0]     pbuser;

  modport requester (
    output pclk, preset_n, paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
           pwakeup, pauser, pwuser,
    input  prdata, pready, pslverr, pruser, pbuser
  );

  modport completer (
    input  pclk, preset_n, paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
           pwakeup, pauser, pwuser,
    output prdata, pready, pslverr, pruser, pbuser
  );

  modport master (
    output pclk, preset_n, paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
           pwakeup, pauser, pwuser,
    input  prdata, pready, pslverr, pruser, pbuser
  );

  modport slave (
    input  pclk, preset_n, paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
           pwakeup, pauser, pwuser,
    output prdata, pready, pslverr, pruser, pbuser
  );
endinterface
`default_nettype wire

// File: rtl/apb_requester_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : apb_requester_bridge
// Brief    : Converts a valid/ready command into one APB transfer with timeout.
// Revision : 1.0 - initial release
// ============================================================================
module apb_requester_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    pclk,
  input  logic                    preset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic                    req_write,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_strb,
  input  logic [2:0]              req_prot,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  apb_requester_bridge_if.requester apb
);
  localparam int                  STRB_WIDTH = DATA_WIDTH / 8;
  localparam int                  CNT_WIDTH  = 16;
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e                  state_q,       state_d;
  logic [ADDR_WIDTH-1:0]   paddr_q,       paddr_d;
  logic                    pwrite_q,      pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_q,      pwdata_d;
  logic [STRB_WIDTH-1:0]   pstrb_q,       pstrb_d;
  logic [2:0]              pprot_q,       pprot_d;
  logic [CNT_WIDTH-1:0]    cnt_q,         cnt_d;
  logic                    rsp_valid_q,   rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q,   rsp_rdata_d;
  logic                    rsp_err_q,     rsp_err_d;
  logic                    rsp_timeout_q, rsp_timeout_d;
  logic [CNT_WIDTH-1:0]    cnt_inc;
  logic                    unused_user;

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state_q       <= IDLE;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      pprot_q       <= '0;
      cnt_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      pprot_q       <= pprot_d;
      cnt_q         <= cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    pprot_d       = pprot_q;
    cnt_d         = cnt_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = '0;
    rsp_err_d     = 1'b0;
    rsp_timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          paddr_d  = req_addr;
          pwrite_d = req_write;
          pwdata_d = req_wdata;
          pstrb_d  = req_write ? req_strb : '0;
          pprot_d  = req_prot;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        // pready wins over a timeout expiring in the same cycle
        if (apb.pready) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : apb.prdata;
          rsp_err_d   = apb.pslverr;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT_C) begin
            rsp_valid_d   = 1'b1;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
            state_d       = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready   = preset_n && (state_q == IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

  assign apb.pclk     = pclk;
  assign apb.preset_n = preset_n;
  assign apb.psel     = (state_q != IDLE);
  assign apb.penable  = (state_q == ACCESS);
  assign apb.pwakeup  = (state_q != IDLE);
  assign apb.paddr    = paddr_q;
  assign apb.pwrite   = pwrite_q;
  assign apb.pwdata   = pwdata_q;
  assign apb.pstrb    = pstrb_q;
  assign apb.pprot    = pprot_q;
  assign apb.pauser   = '0;
  assign apb.pwuser   = '0;

  assign unused_user = ^{apb.pruser, apb.pbuser};
endmodule
`default_nettype wire

// File: tb/tb_apb_requester_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_apb_requester_bridge
// Brief    : Self-checking bench for apb_requester_bridge with a transfer model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_requester_bridge;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        preset_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_write;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic [2:0]  req_prot;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  apb_requester_bridge_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) apb_bus ();

  apb_requester_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
    .pclk        (clk),
    .preset_n    (preset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_write   (req_write),
    .req_wdata   (req_wdata),
    .req_strb    (req_strb),
    .req_prot    (req_prot),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .apb         (apb_bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic sel, input logic en,
                         input logic [31:0] a, input logic w, input logic [31:0] wd,
                         input logic [3:0] st, input logic [2:0] pr);
    chk({tag, "_psel"},    apb_bus.psel,    sel);
    chk({tag, "_penable"}, apb_bus.penable, en);
    chk({tag, "_pwakeup"}, apb_bus.pwakeup, 1'b1);
    chk({tag, "_ready"},   req_ready,       1'b0);
    chk({tag, "_rspv"},    rsp_valid,       1'b0);
    chk({tag, "_paddr"},   apb_bus.paddr,   a);
    chk({tag, "_pwrite"},  apb_bus.pwrite,  w);
    chk({tag, "_pwdata"},  apb_bus.pwdata,  wd);
    chk({tag, "_pstrb"},   apb_bus.pstrb,   st);
    chk({tag, "_pprot"},   apb_bus.pprot,   pr);
  endtask

  task automatic scramble_req();
    req_addr  = $urandom();
    req_write = 1'($urandom_range(0, 1));
    req_wdata = $urandom();
    req_strb  = 4'($urandom_range(0, 15));
    req_prot  = 3'($urandom_range(0, 7));
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_rspv",  rsp_valid,   1'b0);
      chk("idle_rdata", rsp_rdata,   32'h0);
      chk("idle_err",   rsp_err,     1'b0);
      chk("idle_to",    rsp_timeout, 1'b0);
      chk("idle_psel",  apb_bus.psel, 1'b0);
      chk("idle_ready", req_ready,   1'b1);
    end
  endtask

  // Called at a falling edge with the bridge idle; returns at the falling edge
  // of the response cycle with req_valid still high.
  task automatic run_txn(input string tag, input logic [31:0] a, input logic w,
                         input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr,
                         input int waits, input logic serr, input logic [31:0] rd);
    bit          exp_to;
    bit          done;
    int          n_acc;
    logic [3:0]  exp_strb;
    logic [31:0] exp_rdata;
    exp_to    = (waits >= TMO);
    n_acc     = exp_to ? TMO : waits + 1;
    exp_strb  = w ? st : 4'h0;
    exp_rdata = (exp_to || w) ? 32'h0 : rd;

    chk({tag, "_acc_ready"}, req_ready, 1'b1);
    req_valid = 1'b1;
    req_addr  = a;
    req_write = w;
    req_wdata = wd;
    req_strb  = st;
    req_prot  = pr;
    apb_bus.pready  = 1'b0;
    apb_bus.pslverr = 1'b0;
    @(negedge clk);
    chk_bus({tag, "_setup"}, 1'b1, 1'b0, a, w, wd, exp_strb, pr);
    scramble_req();
    for (int k = 0; k < n_acc; k++) begin
      @(negedge clk);
      chk_bus({tag, "_access"}, 1'b1, 1'b1, a, w, wd, exp_strb, pr);
      done = !exp_to && (k == waits);
      apb_bus.pready  = done;
      apb_bus.pslverr = done ? serr : 1'($urandom_range(0, 1));
      apb_bus.prdata  = done ? rd : $urandom();
      scramble_req();
    end
    @(negedge clk);
    apb_bus.pready  = 1'b0;
    apb_bus.pslverr = 1'b0;
    chk({tag, "_rspv"},    rsp_valid,       1'b1);
    chk({tag, "_rdata"},   rsp_rdata,       exp_rdata);
    chk({tag, "_err"},     rsp_err,         exp_to | serr);
    chk({tag, "_timeout"}, rsp_timeout,     exp_to);
    chk({tag, "_psel0"},   apb_bus.psel,    1'b0);
    chk({tag, "_pen0"},    apb_bus.penable, 1'b0);
    chk({tag, "_pwake0"},  apb_bus.pwakeup, 1'b0);
    chk({tag, "_ready1"},  req_ready,       1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    preset_n       = 1'b0;
    req_valid      = 1'b0;
    req_addr       = '0;
    req_write      = 1'b0;
    req_wdata      = '0;
    req_strb       = '0;
    req_prot       = '0;
    apb_bus.pready  = 1'b0;
    apb_bus.pslverr = 1'b0;
    apb_bus.prdata  = '0;
    apb_bus.pruser  = '0;
    apb_bus.pbuser  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready",   req_ready,        1'b0);
    chk("rst_psel",    apb_bus.psel,     1'b0);
    chk("rst_penable", apb_bus.penable,  1'b0);
    chk("rst_pwakeup", apb_bus.pwakeup,  1'b0);
    chk("rst_rspv",    rsp_valid,        1'b0);
    chk("rst_paddr",   apb_bus.paddr,    32'h0);
    chk("rst_pstrb",   apb_bus.pstrb,    4'h0);
    chk("rst_pclk",    apb_bus.pclk,     clk);
    chk("rst_presetn", apb_bus.preset_n, preset_n);
    preset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_ready",   req_ready,        1'b1);
    chk("rel_presetn", apb_bus.preset_n, preset_n);
    chk("rel_pclk",    apb_bus.pclk,     clk);
    chk("pauser_zero", apb_bus.pauser,   1'b0);
    chk("pwuser_zero", apb_bus.pwuser,   1'b0);
    @(negedge clk);

    // Directed transfers
    run_txn("zw_write", 32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 3'd0, 0, 1'b0, 32'hA5A5A5A5);
    idle(2);
    run_txn("rd_wait3", 32'h20, 1'b0, 32'h0BAD0BAD, 4'hF, 3'd2, 3, 1'b0, 32'h12345678);
    idle(1);
    run_txn("wr_slverr", 32'h30, 1'b1, 32'h55AA55AA, 4'h3, 3'd1, 1, 1'b1, 32'h0);
    idle(1);
    run_txn("timeout", 32'h40, 1'b0, 32'h0, 4'h0, 3'd0, TMO + 2, 1'b0, 32'hCAFEF00D);
    idle(1);
    run_txn("ready_at_to", 32'h44, 1'b0, 32'h0, 4'h0, 3'd0, TMO - 1, 1'b0, 32'h87654321);
    idle(1);
    // Back-to-back with req_valid held: next accept in the response cycle
    run_txn("b2b_a", 32'h50, 1'b1, 32'h11111111, 4'hF, 3'd3, 0, 1'b0, 32'h0);
    run_txn("b2b_b", 32'h54, 1'b0, 32'h0, 4'h0, 3'd4, 0, 1'b0, 32'h22222222);
    run_txn("b2b_c", 32'h58, 1'b0, 32'h0, 4'h0, 3'd5, 2, 1'b1, 32'h33333333);
    idle(1);

    // Reset during ACCESS aborts without a response
    req_valid = 1'b1;
    req_addr  = 32'h60;
    req_write = 1'b1;
    req_wdata = 32'h99999999;
    req_strb  = 4'hF;
    req_prot  = 3'd7;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("mid_in_access", apb_bus.penable, 1'b1);
    preset_n       = 1'b0;
    apb_bus.pready = 1'b1;
    @(negedge clk);
    chk("mid_psel",    apb_bus.psel,    1'b0);
    chk("mid_penable", apb_bus.penable, 1'b0);
    chk("mid_pwakeup", apb_bus.pwakeup, 1'b0);
    chk("mid_rspv",    rsp_valid,       1'b0);
    chk("mid_ready",   req_ready,       1'b0);
    chk("mid_paddr",   apb_bus.paddr,   32'h0);
    chk("mid_pwdata",  apb_bus.pwdata,  32'h0);
    chk("mid_pprot",   apb_bus.pprot,   3'd0);
    chk("mid_pwrite",  apb_bus.pwrite,  1'b0);
    preset_n       = 1'b1;
    apb_bus.pready = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rel_ready", req_ready, 1'b1);
    @(negedge clk);
    idle(3);

    // Randomized transfers against the model
    for (int n = 0; n < 24; n++) begin
      int gap;
      run_txn("rnd", $urandom(), 1'($urandom_range(0, 1)), $urandom(),
              4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
              $urandom_range(0, TMO + 2), 1'($urandom_range(0, 1)), $urandom());
      gap = $urandom_range(0, 2);
      if (gap > 0) idle(gap);
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/apb_requester_bridge.md
APB_REQUESTER_BRIDGE -- requirements
Module: apb_requester_bridge

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: APB data width, 8, 16 or 32 only.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: APB address width, 1-32.
REQ-003 SHALL have parameter TIMEOUT, default 255: maximum ACCESS cycles with pready low before abort, 1-65535.
REQ-004 SHALL use one clock; reset is synchronous and active-low.
REQ-005 pclk  input  1  clock; all logic on rising edge.
REQ-006 preset_n  input  1  synchronous active-low reset.
REQ-007 req_valid  input  1  command request.
REQ-008 req_ready  output  1  command accepted when req_valid && req_ready.
REQ-009 req_addr  input  ADDR_WIDTH  target address.
REQ-010 req_write  input  1  1 = write, 0 = read.
REQ-011 req_wdata  input  DATA_WIDTH  write data.
REQ-012 req_strb  input  DATA_WIDTH/8  write byte strobes.
REQ-013 req_prot  input  3  protection attributes.
REQ-014 rsp_valid  output  1  one-cycle completion pulse.
REQ-015 rsp_rdata  output  DATA_WIDTH  read data, qualified by rsp_valid.
REQ-016 rsp_err  output  1  pslverr or timeout, qualified by rsp_valid.
REQ-017 rsp_timeout  output  1  abort due to timeout, qualified by rsp_valid.
REQ-018 apb  APB.requester modport  -  APB bus driven by this block.

Function
REQ-019 SHALL drive apb.pclk = pclk and apb.preset_n = preset_n combinationally.
REQ-020 SHALL implement states IDLE, SETUP, ACCESS; req_ready = 1 only in IDLE.
REQ-021 IDLE + accept: capture addr/write/wdata/prot into paddr/pwrite/pwdata/pprot; pstrb = req_strb for writes, all-zero for reads; next state SETUP.
REQ-022 SETUP: psel=1, penable=0, exactly one cycle; clear timeout counter; next state ACCESS.
REQ-023 ACCESS: psel=1, penable=1; stay while pready=0 and timeout not reached.
REQ-024 ACCESS with pready=1: next cycle rsp_valid=1, rsp_rdata = prdata (0 for writes), rsp_err = pslverr, rsp_timeout=0, psel=0, penable=0, state IDLE.
REQ-025 Timeout counter SHALL increment once per ACCESS cycle with pready=0; on the TIMEOUT-th such cycle, next cycle rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0, psel=penable=0, state IDLE.
REQ-026 pready=1 in the cycle that would trigger timeout SHALL complete normally (pready has priority).
REQ-027 paddr, pwrite, pwdata, pstrb, pprot SHALL remain stable from SETUP through the last ACCESS cycle.
REQ-028 Zero-wait latency: accept at cycle N -> SETUP N+1 -> ACCESS N+2 -> rsp_valid N+3.
REQ-029 IDLE coincides with rsp_valid cycle, so a new command may be accepted then; psel SHALL be low for at least one cycle between transfers.
REQ-030 pwakeup SHALL be 1 from the cycle after accept through the final ACCESS cycle, else 0.
REQ-031 pauser and pwuser SHALL be driven all-zero; pruser and pbuser ignored.
REQ-032 rsp_rdata, rsp_err, rsp_timeout SHALL be 0 whenever rsp_valid=0.

Reset
REQ-033 preset_n=0 at a clock edge SHALL force IDLE, psel=0, penable=0, pwakeup=0, rsp_valid=0, rsp_err=0, rsp_timeout=0, rsp_rdata=0, paddr=0, pwdata=0, pstrb=0, pprot=0, pwrite=0, counter=0.
REQ-034 Reset mid-transfer SHALL abort silently: no rsp_valid is issued for the aborted command.
REQ-035 req_ready SHALL be 0 while preset_n=0 and 1 the first cycle after release.

Verification
REQ-036 Zero-wait write addr 0x10, wdata 0xDEADBEEF, strb 0xF -> SETUP/ACCESS each one cycle, rsp_valid at N+3, rsp_err=0, rsp_rdata=0.
REQ-037 Read addr 0x20, pready low 3 cycles, prdata 0x12345678 -> pstrb=0, rsp_valid at N+6, rsp_rdata=0x12345678.
REQ-038 Write with pslverr=1 on completing cycle -> rsp_err=1, rsp_timeout=0.
REQ-039 TIMEOUT=4, pready never asserted -> exactly 4 ACCESS cycles, rsp_err=1, rsp_timeout=1; repeat with pready=1 on 4th cycle -> normal completion.
REQ-040 Back-to-back commands with req_valid held high -> second accept in rsp_valid cycle, psel low exactly one cycle between transfers.
REQ-041 Assert preset_n=0 during ACCESS -> psel/penable low next edge, no rsp_valid, req_ready=1 after release.
